fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch stage sitting directly upstream of controller_fsm. It owns the program counter (PC) and instruction register (IR), issues reads to instruction memory, and buffers the returned word. It presents Opcode/Operand to the controller and obeys the controller's LoadIR, IncPC, SelPC and LoadPC strobes. A fetch state machine tolerates variable memory latency and signals a stall while the word for the current PC is not yet available.

Parameters:
PC_WIDTH, 8, width of PC and memory address
INSTR_WIDTH, 8, instruction word width; opcode = IR[INSTR_WIDTH-1 -: 4], operand = IR[3:0]
WAIT_LIMIT, 16, cycles in WAIT without a response before the request is re-issued

Ports:
Clk  in  1  system clock, rising edge
CLB  in  1  synchronous active-low reset
i_LoadIR  in  1  controller strobe: copy buffered word into IR
i_IncPC  in  1  controller strobe: PC <= PC+1
i_SelPC  in  1  jump source select: 1 = IR operand (immediate), 0 = i_RegData
i_LoadPC  in  1  controller strobe: load PC from selected source
i_RegData  in  PC_WIDTH  register-file value used as jump target
o_MemReq  out  1  instruction memory read request (one-cycle pulse)
o_MemAddr  out  PC_WIDTH  read address, equal to PC while o_MemReq=1
i_MemData  in  INSTR_WIDTH  read data
i_MemValid  in  1  read data valid
o_Opcode  out  4  IR opcode field, to controller_fsm Opcode
o_Operand  out  4  IR operand field (register index or immediate)
o_PC  out  PC_WIDTH  current PC
o_Ready  out  1  buffered word for current PC is valid
o_Stall  out  1  i_LoadIR asserted while o_Ready=0

Behaviour:
- One clock (Clk). Reset is synchronous, active-low (CLB=0 sampled on the rising edge).
- Reset values: PC=0, IR=0 (o_Opcode=0000 NOP), buffer=0, state=REQ, wait counter=0, o_MemReq=0, o_Ready=0, o_Stall=0. The first request issues in the first cycle after CLB is released. Reset mid-fetch abandons the request; late i_MemValid is ignored until the new WAIT.
- PC update, in priority order:
  - i_LoadPC: PC <= i_SelPC ? zero-extended IR operand : i_RegData[PC_WIDTH-1:0].
  - else i_IncPC: PC <= PC+1, wrapping modulo 2^PC_WIDTH (0xFF -> 0x00).
  - else PC holds.
  - "PC change" means an edge where i_LoadPC or i_IncPC is 1, even if the value is unchanged.
- Fetch FSM states: REQ, WAIT, READY.
  - REQ: o_MemReq=1, o_MemAddr=PC; go to WAIT; counter cleared.
  - WAIT: i_MemValid=1 -> capture i_MemData into buffer, go to READY. Otherwise counter++; when counter reaches WAIT_LIMIT-1 -> REQ (retry).
  - READY: o_Ready=1; hold until a PC change.
  - PC change in any state -> REQ next cycle, buffer invalidated (o_Ready=0). An i_MemValid in the same cycle as a PC change is discarded.
  - i_MemValid outside WAIT is ignored.
- IR:
  - i_LoadIR && o_Ready: IR <= buffer on that edge. o_Opcode and o_Operand update the following cycle.
  - i_LoadIR && !o_Ready: IR holds; o_Stall=1 combinationally in that cycle.
  - LoadIR with IncPC or LoadPC in the same cycle: IR takes the word for the old PC, PC updates, and a new fetch starts.
  - LoadPC with SelPC=1 uses the IR operand value before any same-cycle IR load.
- o_MemReq is registered: high for exactly one cycle per REQ entry.

Decomposition:
- cpu_pkg (shared with controller_fsm): opcode constants (ADD 0001 … HALT 1111), PC_WIDTH/INSTR_WIDTH defaults, fetch state encoding.
- One sub-module, program_counter: PC register with load/increment priority and wrap. The fetch FSM, buffer and IR stay in fetch_unit.

Test Plan:
1. Hold CLB=0 for 2 cycles -> PC=0x00, o_Opcode=0000, o_MemReq=0, o_Ready=0. Release CLB -> next cycle o_MemReq=1, o_MemAddr=0x00.
2. Memory returns 0x1A three cycles after request -> o_Ready=1. Pulse i_LoadIR -> next cycle o_Opcode=0001, o_Operand=0xA.
3. PC=0x05, word@5=0x4C, i_LoadIR+i_IncPC in the same cycle -> IR=0x4C, PC=0x06, o_Ready=0, next o_MemReq with addr 0x06. Repeat at PC=0xFF -> PC=0x00.
4. IR operand=0x9: LoadPC with SelPC=1 -> PC=0x09. LoadPC with SelPC=0, i_RegData=0x3C -> PC=0x3C. LoadPC+IncPC together -> PC=0x3C (load wins).
5. No i_MemValid for 16 cycles in WAIT -> o_MemReq re-pulses with the same address. i_LoadIR meanwhile -> o_Stall=1 and IR unchanged.
6. i_MemValid=1 coincident with i_IncPC -> data discarded, o_Ready stays 0, new request to PC+1. CLB=0 during WAIT -> all outputs reach reset values on the next edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Definitions shared by the fetch unit and controller_fsm: opcodes, default
// widths and the fetch state encoding.
package cpu_pkg;

  localparam int PC_WIDTH_DEF    = 8;
  localparam int INSTR_WIDTH_DEF = 8;
  localparam int WAIT_LIMIT_DEF  = 16;

  typedef enum logic [3:0] {
    OP_NOP  = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_SUB  = 4'b0010,
    OP_AND  = 4'b0011,
    OP_OR   = 4'b0100,
    OP_XOR  = 4'b0101,
    OP_LDI  = 4'b0110,
    OP_LD   = 4'b0111,
    OP_ST   = 4'b1000,
    OP_JMP  = 4'b1001,
    OP_JZ   = 4'b1010,
    OP_JR   = 4'b1011,
    OP_HALT = 4'b1111
  } opcode_t;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } fetchState_t;

endpackage

// File: rtl/fetch_unit_program_counter.sv
// Program counter: a jump load takes priority over increment; increment
// wraps modulo 2^PC_WIDTH.
module program_counter #(
  parameter int PC_WIDTH = 8
) (
  input  logic                Clk,
  input  logic                CLB,
  input  logic                load,
  input  logic                inc,
  input  logic [PC_WIDTH-1:0] loadValue,
  output logic [PC_WIDTH-1:0] pc
);

  always_ff @(posedge Clk) begin
    if (!CLB)      pc <= '0;
    else if (load) pc <= loadValue;
    else if (inc)  pc <= pc + PC_WIDTH'(1);
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns PC and IR, fetches from instruction memory
// and buffers the word for the current PC until the controller loads it.
//   state | meaning
//   REQ   | read request pulse for the current PC (held off in the reset cycle)
//   WAIT  | waiting for read data; retries after WAIT_LIMIT idle cycles
//   READY | buffered word valid for the current PC
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int PC_WIDTH    = PC_WIDTH_DEF,
  parameter int INSTR_WIDTH = INSTR_WIDTH_DEF,
  parameter int WAIT_LIMIT  = WAIT_LIMIT_DEF
) (
  input  logic                   Clk,
  input  logic                   CLB,
  input  logic                   i_LoadIR,
  input  logic                   i_IncPC,
  input  logic                   i_SelPC,
  input  logic                   i_LoadPC,
  input  logic [PC_WIDTH-1:0]    i_RegData,
  output logic                   o_MemReq,
  output logic [PC_WIDTH-1:0]    o_MemAddr,
  input  logic [INSTR_WIDTH-1:0] i_MemData,
  input  logic                   i_MemValid,
  output logic [3:0]             o_Opcode,
  output logic [3:0]             o_Operand,
  output logic [PC_WIDTH-1:0]    o_PC,
  output logic                   o_Ready,
  output logic                   o_Stall
);

  localparam int CNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;

  fetchState_t            stateQ, stateNext;
  logic [CNT_W-1:0]       waitCnt;
  logic [PC_WIDTH-1:0]    pc, jumpTarget;
  logic [INSTR_WIDTH-1:0] irQ, bufQ;
  logic                   memReqQ, pcChange, ready, captureWord;

  assign pcChange   = i_LoadPC | i_IncPC;
  // Immediate jumps use the IR as it stands before any same-cycle IR load.
  assign jumpTarget = i_SelPC ? PC_WIDTH'(irQ[3:0]) : i_RegData;

  program_counter #(.PC_WIDTH(PC_WIDTH)) u_pc (
    .Clk       (Clk),
    .CLB       (CLB),
    .load      (i_LoadPC),
    .inc       (i_IncPC),
    .loadValue (jumpTarget),
    .pc        (pc)
  );

  always_ff @(posedge Clk) begin
    if (!CLB) stateQ <= REQ;
    else      stateQ <= stateNext;
  end

  // REQ is left only once its request pulse has been issued.
  always_comb begin
    stateNext = stateQ;
    if (pcChange) begin
      stateNext = REQ;
    end else begin
      case (stateQ)
        REQ:     if (memReqQ) stateNext = WAIT;
        WAIT: begin
          if (i_MemValid)                             stateNext = READY;
          else if (waitCnt == CNT_W'(WAIT_LIMIT - 1)) stateNext = REQ;
        end
        READY:   stateNext = READY;
        default: stateNext = REQ;
      endcase
    end
  end

  always_comb begin
    ready       = (stateQ == READY);
    captureWord = (stateQ == WAIT) && i_MemValid && !pcChange;
    o_Stall     = i_LoadIR && !ready;
  end

  always_ff @(posedge Clk) begin
    if (!CLB) begin
      memReqQ <= 1'b0;
      waitCnt <= '0;
      bufQ    <= '0;
      irQ     <= '0;
    end else begin
      memReqQ <= (stateNext == REQ);
      if (stateQ == WAIT) waitCnt <= waitCnt + CNT_W'(1);
      else                waitCnt <= '0;
      if (captureWord)       bufQ <= i_MemData;
      if (i_LoadIR && ready) irQ  <= bufQ;
    end
  end

  assign o_MemReq  = memReqQ;
  assign o_MemAddr = pc;
  assign o_PC      = pc;
  assign o_Ready   = ready;
  assign o_Opcode  = irQ[INSTR_WIDTH-1 -: 4];
  assign o_Operand = irQ[3:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, fetch, PC increment/jump, retry,
// discard and mid-fetch reset scenarios with hand-computed expectations.
module tb_fetch_unit;

  logic       Clk = 1'b0;
  logic       CLB = 1'b0;
  logic       i_LoadIR = 1'b0, i_IncPC = 1'b0, i_SelPC = 1'b0, i_LoadPC = 1'b0;
  logic [7:0] i_RegData = 8'h00;
  logic [7:0] i_MemData = 8'h00;
  logic       i_MemValid = 1'b0;
  logic       o_MemReq, o_Ready, o_Stall;
  logic [7:0] o_MemAddr, o_PC;
  logic [3:0] o_Opcode, o_Operand;

  int vecs = 0;
  int errs = 0;

  fetch_unit dut (
    .Clk(Clk), .CLB(CLB),
    .i_LoadIR(i_LoadIR), .i_IncPC(i_IncPC), .i_SelPC(i_SelPC), .i_LoadPC(i_LoadPC),
    .i_RegData(i_RegData),
    .o_MemReq(o_MemReq), .o_MemAddr(o_MemAddr),
    .i_MemData(i_MemData), .i_MemValid(i_MemValid),
    .o_Opcode(o_Opcode), .o_Operand(o_Operand), .o_PC(o_PC),
    .o_Ready(o_Ready), .o_Stall(o_Stall)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Bounded wait for a request pulse, then check its address.
  task automatic waitReq(input logic [7:0] addr);
    int n = 0;
    while (o_MemReq !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    vecs++;
    if (o_MemReq !== 1'b1) begin
      errs++;
      $display("FAIL waitReq timeout: memReq=%b want 1", o_MemReq);
    end else if (o_MemAddr !== addr) begin
      errs++;
      $display("FAIL waitReq addr: got %h want %h", o_MemAddr, addr);
    end
  endtask

  // Answer the pending request one cycle into WAIT.
  task automatic serve(input logic [7:0] addr, input logic [7:0] data);
    waitReq(addr);
    tick();
    i_MemValid = 1'b1;
    i_MemData  = data;
    tick();
    i_MemValid = 1'b0;
  endtask

  task automatic test_reset();
    CLB = 1'b0;
    tick();
    tick();
    vecs++; if (o_PC !== 8'h00)     begin errs++; $display("FAIL reset pc: got %h want 00", o_PC); end
    vecs++; if (o_Opcode !== 4'h0)  begin errs++; $display("FAIL reset opcode: got %h want 0", o_Opcode); end
    vecs++; if (o_MemReq !== 1'b0)  begin errs++; $display("FAIL reset memReq: got %b want 0", o_MemReq); end
    vecs++; if (o_Ready !== 1'b0)   begin errs++; $display("FAIL reset ready: got %b want 0", o_Ready); end
    vecs++; if (o_Stall !== 1'b0)   begin errs++; $display("FAIL reset stall: got %b want 0", o_Stall); end
    CLB = 1'b1;
    tick();
    vecs++; if (o_MemReq !== 1'b1)  begin errs++; $display("FAIL first req: got %b want 1", o_MemReq); end
    vecs++; if (o_MemAddr !== 8'h00) begin errs++; $display("FAIL first addr: got %h want 00", o_MemAddr); end
    tick();
    vecs++; if (o_MemReq !== 1'b0)  begin errs++; $display("FAIL req pulse width: got %b want 0", o_MemReq); end
  endtask

  task automatic test_fetch();
    tick();
    i_MemValid = 1'b1;
    i_MemData  = 8'h1A;
    tick();
    i_MemValid = 1'b0;
    vecs++; if (o_Ready !== 1'b1) begin errs++; $display("FAIL fetch ready: got %b want 1", o_Ready); end
    i_LoadIR = 1'b1;
    #1;
    vecs++; if (o_Stall !== 1'b0) begin errs++; $display("FAIL fetch stall: got %b want 0", o_Stall); end
    tick();
    i_LoadIR = 1'b0;
    vecs++; if (o_Opcode !== 4'h1)  begin errs++; $display("FAIL fetch opcode: got %h want 1", o_Opcode); end
    vecs++; if (o_Operand !== 4'hA) begin errs++; $display("FAIL fetch operand: got %h want A", o_Operand); end
  endtask

  task automatic test_incpc();
    i_LoadPC = 1'b1; i_SelPC = 1'b0; i_RegData = 8'h05;
    tick();
    i_LoadPC = 1'b0;
    serve(8'h05, 8'h4C);
    i_LoadIR = 1'b1; i_IncPC = 1'b1;
    tick();
    i_LoadIR = 1'b0; i_IncPC = 1'b0;
    vecs++; if (o_PC !== 8'h06)      begin errs++; $display("FAIL inc pc: got %h want 06", o_PC); end
    vecs++; if (o_Opcode !== 4'h4)   begin errs++; $display("FAIL inc opcode: got %h want 4", o_Opcode); end
    vecs++; if (o_Operand !== 4'hC)  begin errs++; $display("FAIL inc operand: got %h want C", o_Operand); end
    vecs++; if (o_Ready !== 1'b0)    begin errs++; $display("FAIL inc ready: got %b want 0", o_Ready); end
    vecs++; if (o_MemReq !== 1'b1)   begin errs++; $display("FAIL inc req: got %b want 1", o_MemReq); end
    vecs++; if (o_MemAddr !== 8'h06) begin errs++; $display("FAIL inc addr: got %h want 06", o_MemAddr); end
    i_LoadPC = 1'b1; i_RegData = 8'hFF;
    tick();
    i_LoadPC = 1'b0;
    serve(8'hFF, 8'h77);
    i_LoadIR = 1'b1; i_IncPC = 1'b1;
    tick();
    i_LoadIR = 1'b0; i_IncPC = 1'b0;
    vecs++; if (o_PC !== 8'h00)      begin errs++; $display("FAIL wrap pc: got %h want 00", o_PC); end
    vecs++; if (o_Opcode !== 4'h7)   begin errs++; $display("FAIL wrap opcode: got %h want 7", o_Opcode); end
    vecs++; if (o_MemAddr !== 8'h00) begin errs++; $display("FAIL wrap addr: got %h want 00", o_MemAddr); end
  endtask

  task automatic test_jump();
    serve(8'h00, 8'h29);
    i_LoadIR = 1'b1;
    tick();
    i_LoadIR = 1'b0;
    i_LoadPC = 1'b1; i_SelPC = 1'b1; i_RegData = 8'h55;
    tick();
    vecs++; if (o_PC !== 8'h09) begin errs++; $display("FAIL jump imm: got %h want 09", o_PC); end
    i_SelPC = 1'b0; i_RegData = 8'h3C;
    tick();
    vecs++; if (o_PC !== 8'h3C) begin errs++; $display("FAIL jump reg: got %h want 3C", o_PC); end
    i_IncPC = 1'b1;
    tick();
    i_IncPC = 1'b0; i_LoadPC = 1'b0;
    vecs++; if (o_PC !== 8'h3C) begin errs++; $display("FAIL load priority: got %h want 3C", o_PC); end
    serve(8'h3C, 8'h5E);
    i_LoadIR = 1'b1; i_LoadPC = 1'b1; i_SelPC = 1'b1;
    tick();
    i_LoadIR = 1'b0; i_LoadPC = 1'b0; i_SelPC = 1'b0;
    vecs++; if (o_PC !== 8'h09)     begin errs++; $display("FAIL old operand jump: got %h want 09", o_PC); end
    vecs++; if (o_Operand !== 4'hE) begin errs++; $display("FAIL jump ir load: got %h want E", o_Operand); end
  endtask

  task automatic test_timeout();
    waitReq(8'h09);
    i_LoadIR = 1'b1;
    #1;
    vecs++; if (o_Stall !== 1'b1) begin errs++; $display("FAIL stall: got %b want 1", o_Stall); end
    for (int k = 0; k < 16; k++) tick();
    vecs++; if (o_MemReq !== 1'b0) begin errs++; $display("FAIL retry early: got %b want 0", o_MemReq); end
    tick();
    vecs++; if (o_MemReq !== 1'b1)   begin errs++; $display("FAIL retry req: got %b want 1", o_MemReq); end
    vecs++; if (o_MemAddr !== 8'h09) begin errs++; $display("FAIL retry addr: got %h want 09", o_MemAddr); end
    i_LoadIR = 1'b0;
    vecs++; if (o_Opcode !== 4'h5 || o_Operand !== 4'hE)
      begin errs++; $display("FAIL stall ir hold: got %h%h want 5E", o_Opcode, o_Operand); end
  endtask

  task automatic test_discard();
    i_MemValid = 1'b1; i_MemData = 8'hCC;
    tick();
    i_MemValid = 1'b0;
    tick();
    vecs++; if (o_Ready !== 1'b0) begin errs++; $display("FAIL valid outside wait: got %b want 0", o_Ready); end
    i_MemValid = 1'b1; i_MemData = 8'hAB; i_IncPC = 1'b1;
    tick();
    i_MemValid = 1'b0; i_IncPC = 1'b0;
    vecs++; if (o_Ready !== 1'b0)    begin errs++; $display("FAIL discard ready: got %b want 0", o_Ready); end
    vecs++; if (o_MemReq !== 1'b1)   begin errs++; $display("FAIL discard req: got %b want 1", o_MemReq); end
    vecs++; if (o_MemAddr !== 8'h0A) begin errs++; $display("FAIL discard addr: got %h want 0A", o_MemAddr); end
    tick();
    vecs++; if (o_Ready !== 1'b0) begin errs++; $display("FAIL discard later ready: got %b want 0", o_Ready); end
  endtask

  task automatic test_reset_mid();
    CLB = 1'b0; i_MemValid = 1'b1; i_MemData = 8'h33;
    tick();
    vecs++; if (o_PC !== 8'h00)    begin errs++; $display("FAIL midreset pc: got %h want 00", o_PC); end
    vecs++; if (o_Opcode !== 4'h0 || o_Operand !== 4'h0)
      begin errs++; $display("FAIL midreset ir: got %h%h want 00", o_Opcode, o_Operand); end
    vecs++; if (o_MemReq !== 1'b0) begin errs++; $display("FAIL midreset req: got %b want 0", o_MemReq); end
    vecs++; if (o_Ready !== 1'b0)  begin errs++; $display("FAIL midreset ready: got %b want 0", o_Ready); end
    CLB = 1'b1;
    tick();
    i_MemValid = 1'b0;
    vecs++; if (o_MemReq !== 1'b1 || o_MemAddr !== 8'h00)
      begin errs++; $display("FAIL postreset req: got %b/%h want 1/00", o_MemReq, o_MemAddr); end
    tick();
    tick();
    vecs++; if (o_Ready !== 1'b0) begin errs++; $display("FAIL late valid: got %b want 0", o_Ready); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_incpc();
    test_jump();
    test_timeout();
    test_discard();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
